// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_t     : receiver FSM state encoding
//   PRESCALE_8/16/32 : the legal oversampling ratios
//   majority3()    : 2-of-3 vote used by the optional majority sampler
//   prescale_legal(): true when a prescale value is one of the legal ratios
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// edge_bit_counter: oversampling edge counter and data-bit counter.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : count edges (frame in progress); counters clear while low
//   count_bits  : advance bit_cnt at each bit boundary (data phase)
//   prescale    : latched oversampling ratio for the current frame
//   edge_cnt    : position inside the current bit, 0..prescale-1
//   bit_cnt     : index of the data bit being received
//   bit_done    : high on the last edge of a bit (edge_cnt == prescale-1)
// Any prescale value wraps: edge_cnt visits every 6-bit value, so
// prescale-1 is always reached and a bit can never last forever.
module edge_bit_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             count_bits,
  input  logic [5:0]       prescale,
  output logic [5:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             bit_done
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  assign bit_done = enable && (edge_cnt == (prescale - 6'd1));

  // edge counter: runs during a frame, wraps at each bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= 6'd0;
    end else if (!enable) begin
      edge_cnt <= 6'd0;
    end else if (bit_done) begin
      edge_cnt <= 6'd0;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // data bit counter: advances once per bit in the data phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (!enable) begin
      bit_cnt <= '0;
    end else if (count_bits && bit_done) begin
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + {{(BIT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller (start/data/parity/stop framing).
//   CLK, RST     : clock, asynchronous active-high reset
//   RX_IN        : serial line, idle high, already synchronised to CLK
//   Prescale     : oversampling ratio (8, 16 or 32), latched at frame start
//   PAR_EN       : frame carries a parity bit
//   PAR_TYP      : parity type, consumed by the external parity checker
//   par_err      : combinational result from the external parity checker
//   sampled_bit  : value of the bit currently being received
//   par_chk_en   : one-cycle strobe asking the parity checker for a result
//   P_DATA       : received data word, LSB first on the line
//   data_valid   : one-cycle pulse for a frame with no errors
//   par_err_flag : parity error of the last frame
//   stp_err      : stop bit of the last frame was 0
// Build option: define MAJORITY_SAMPLE_EN to vote 2-of-3 over the samples
// at edges Prescale/2-1, Prescale/2 and Prescale/2+1; otherwise the single
// sample at Prescale/2 is used. Timing is identical in both builds.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err_flag,
  output logic                  stp_err
);

  import uart_rx_pkg::*;

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  rx_state_t        state;
  rx_state_t        next_state;
  logic [5:0]       presc_lat;
  logic             presc_ok;
  logic [5:0]       edge_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             bit_done;
  logic [5:0]       half;
  logic [5:0]       pt_mid;
  logic [5:0]       pt_late;
  logic [5:0]       pt_act;
  logic             start_entry;
  logic             in_frame;
  logic             samp_mid;
  logic             sample_value;

  // PAR_TYP goes straight to the parity checker; this block only carries it
  logic unused_par_typ;
  assign unused_par_typ = PAR_TYP;

  assign half        = {1'b0, presc_lat[5:1]};
  assign pt_mid      = half;
  assign pt_late     = half + 6'd1;
  assign pt_act      = half + 6'd2;
  assign start_entry = (state == IDLE) && !RX_IN;
  assign in_frame    = (state != IDLE);

  edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_W      (BIT_W)
  ) u_counter (
    .clk        (CLK),
    .rst        (RST),
    .enable     (in_frame),
    .count_bits (state == DATA),
    .prescale   (presc_lat),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_done   (bit_done)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; every transition except IDLE->START is on a bit boundary
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
      START: begin
        if (bit_done) begin
          // a start bit that reads back high was a line glitch
          next_state = sampled_bit ? IDLE : DATA;
        end else begin
          next_state = START;
        end
      end
      DATA: begin
        if (bit_done && (bit_cnt == LAST_BIT)) begin
          next_state = PAR_EN ? PARITY : STOP;
        end else begin
          next_state = DATA;
        end
      end
      PARITY: begin
        if (bit_done) begin
          next_state = STOP;
        end else begin
          next_state = PARITY;
        end
      end
      STOP: begin
        if (bit_done) begin
          next_state = IDLE;
        end else begin
          next_state = STOP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // latch the oversampling ratio for the whole frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_lat <= 6'd0;
      presc_ok  <= 1'b0;
    end else if (start_entry) begin
      presc_lat <= Prescale;
      presc_ok  <= prescale_legal(Prescale);
    end else begin
      presc_lat <= presc_lat;
      presc_ok  <= presc_ok;
    end
  end

  // centre sample, taken at edge Prescale/2
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_mid <= 1'b0;
    end else if (in_frame && (edge_cnt == pt_mid)) begin
      samp_mid <= RX_IN;
    end else begin
      samp_mid <= samp_mid;
    end
  end

`ifdef MAJORITY_SAMPLE_EN
  logic [5:0] pt_early;
  logic       samp_early;

  assign pt_early = half - 6'd1;

  // early sample, taken at edge Prescale/2-1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_early <= 1'b0;
    end else if (in_frame && (edge_cnt == pt_early)) begin
      samp_early <= RX_IN;
    end else begin
      samp_early <= samp_early;
    end
  end

  // the late sample is the live line at edge Prescale/2+1
  assign sample_value = majority3(samp_early, samp_mid, RX_IN);
`else
  assign sample_value = samp_mid;
`endif

  // publish the bit value once all sample points have been seen
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sampled_bit <= 1'b0;
    end else if (in_frame && (edge_cnt == pt_late)) begin
      sampled_bit <= sample_value;
    end else begin
      sampled_bit <= sampled_bit;
    end
  end

  // shift data LSB first, one edge after sampled_bit settles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA <= '0;
    end else if ((state == DATA) && (edge_cnt == pt_act)) begin
      P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
    end else begin
      P_DATA <= P_DATA;
    end
  end

  // parity strobe is high exactly on edge Prescale/2+2 of the parity bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_chk_en   <= 1'b0;
      par_err_flag <= 1'b0;
    end else begin
      par_chk_en <= (state == PARITY) && (edge_cnt == pt_late);
      if (start_entry) begin
        par_err_flag <= 1'b0;
      end else if (par_chk_en) begin
        par_err_flag <= par_err;
      end else begin
        par_err_flag <= par_err_flag;
      end
    end
  end

  // stop bit check and frame-good pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stp_err    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      // frames at an illegal ratio are never reported as good
      data_valid <= (state == STOP) && bit_done && presc_ok && !par_err_flag && !stp_err;
      if (start_entry) begin
        stp_err <= 1'b0;
      end else if ((state == STOP) && (edge_cnt == pt_act)) begin
        stp_err <= ~sampled_bit;
      end else begin
        stp_err <= stp_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, hand-written
// corner sequences (glitch, back-to-back, reset mid-frame, illegal ratio)
// and random frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       par_err;
  logic       sampled_bit;
  logic       par_chk_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err_flag;
  logic       stp_err;

  int n_cmp     = 0;
  int n_err     = 0;
  int dv_total  = 0;
  int chk_total = 0;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .par_err      (par_err),
    .sampled_bit  (sampled_bit),
    .par_chk_en   (par_chk_en),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err_flag (par_err_flag),
    .stp_err      (stp_err)
  );

  always #5 CLK = ~CLK;

  // downstream parity checker: error when data+parity ones-count parity differs from PAR_TYP
  assign par_err = par_chk_en & (((^P_DATA) ^ sampled_bit) != PAR_TYP);

  // count strobes away from the active edge
  always @(negedge CLK) begin
    if (data_valid) dv_total = dv_total + 1;
    if (par_chk_en) chk_total = chk_total + 1;
  end

  typedef struct {
    int         presc;
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
    bit         par_bit;
    bit         stop;
    int         flip_cyc;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_serr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // drive one frame; flip_cyc inverts the line on one cycle, stop_after truncates the frame
  task automatic drive_frame(input int presc, input logic [7:0] data, input bit par_en,
                             input bit par_bit, input bit stop, input int flip_cyc,
                             input int stop_after, input bit scramble);
    int nbits;
    logic [10:0] bits;
    nbits = par_en ? 11 : 10;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (par_en) begin
      bits[9] = par_bit;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    Prescale = 6'(presc);
    PAR_EN = par_en;
    for (int c = 0; c < nbits * presc; c++) begin
      if (c == stop_after) break;
      @(negedge CLK);
      RX_IN = bits[c / presc] ^ (c == flip_cyc);
      // the ratio latched at the start bit must be used for the whole frame
      if (scramble && c == 2) Prescale = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic run_frame(input string name, input int presc, input logic [7:0] data,
                           input bit par_en, input bit par_typ, input bit par_bit, input bit stop,
                           input int flip_cyc, input bit scramble, input bit exp_valid,
                           input logic [7:0] exp_data, input bit exp_perr, input bit exp_serr);
    int dv0;
    int ck0;
    dv0 = dv_total;
    ck0 = chk_total;
    PAR_TYP = par_typ;
    drive_frame(presc, data, par_en, par_bit, stop, flip_cyc, -1, scramble);
    idle(6);
    check({name, " data_valid pulses"}, 32'(dv_total - dv0), {31'd0, exp_valid});
    check({name, " par_chk_en cycles"}, 32'(chk_total - ck0), {31'd0, par_en});
    check({name, " P_DATA"}, {24'd0, P_DATA}, {24'd0, exp_data});
    check({name, " par_err_flag"}, {31'd0, par_err_flag}, {31'd0, exp_perr});
    check({name, " stp_err"}, {31'd0, stp_err}, {31'd0, exp_serr});
  endtask

  // frame-level reference: good when stop is 1 and, if present, parity matches
  function automatic bit ref_par_ok(input logic [7:0] d, input bit pb, input bit typ);
    int ones;
    ones = $countones(d) + int'(pb);
    return (ones % 2) == int'(typ);
  endfunction

  initial begin
    int dv0;
    logic [7:0] d;
    bit pe, pt, pb, st, pok;
    int ps;

    // expected results worked out by hand from the framing rules
    vecs[0] = '{8,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8,  8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[4] = '{32, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, 8'h07, 1'b0, 1'b0};
    // data bit 0 inverted only at its edge Prescale/2 (frame cycle 16+8+1)
`ifdef MAJORITY_SAMPLE_EN
    vecs[5] = '{16, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 25, 1'b1, 8'hF0, 1'b0, 1'b0};
`else
    vecs[5] = '{16, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 25, 1'b1, 8'hF1, 1'b0, 1'b0};
`endif
    vecs[6] = '{32, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8,  8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1, 8'hFF, 1'b0, 1'b0};

    RST = 1'b1;
    RX_IN = 1'b1;
    Prescale = PRESCALE_8;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset outputs", {20'd0, P_DATA, sampled_bit, par_chk_en, data_valid, par_err_flag, stp_err}, 32'd0);
    RST = 1'b0;
    idle(4);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].presc, vecs[i].data, vecs[i].par_en,
                vecs[i].par_typ, vecs[i].par_bit, vecs[i].stop, vecs[i].flip_cyc, 1'b0,
                vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_serr);
    end

    // back-to-back frames with no idle gap
    dv0 = dv_total;
    PAR_TYP = 1'b0;
    drive_frame(16, 8'h11, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    drive_frame(16, 8'hEE, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(6);
    check("b2b data_valid pulses", 32'(dv_total - dv0), 32'd2);
    check("b2b P_DATA", {24'd0, P_DATA}, 32'h0000_00EE);

    // two-cycle low glitch in IDLE must be rejected
    dv0 = dv_total;
    Prescale = PRESCALE_16;
    PAR_EN = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    idle(40);
    check("glitch data_valid pulses", 32'(dv_total - dv0), 32'd0);
    run_frame("after glitch", 16, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0);

    // illegal ratios: no lock-up, next legal frame is received
    PAR_EN = 1'b1;
    Prescale = 6'd5;
    repeat (12) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    idle(64 * 5);
    Prescale = 6'd0;
    repeat (100) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    idle(64 * 64);
    run_frame("after illegal", 8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);

    // reset after four data bits aborts the frame
    PAR_TYP = 1'b0;
    drive_frame(16, 8'hC3, 1'b0, 1'b0, 1'b1, -1, 5 * 16 + 8, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    RX_IN = 1'b1;
    #1;
    check("mid-frame reset outputs", {20'd0, P_DATA, sampled_bit, par_chk_en, data_valid, par_err_flag, stp_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dv0 = dv_total;
    idle(40);
    check("aborted frame data_valid pulses", 32'(dv_total - dv0), 32'd0);
    run_frame("after reset", 16, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

    // random frames against the frame-level reference
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 2))
        0: ps = 8;
        1: ps = 16;
        default: ps = 32;
      endcase
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) != 0);
      pok = ref_par_ok(d, pb, pt);
      run_frame($sformatf("rand%0d", r), ps, d, pe, pt, pb, st, -1, 1'b1,
                st && (!pe || pok), d, pe && !pok, !st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
